// File: rtl/emmc_ddr_tx_sched_if.sv
// Host-side handshake and DDR output bundle for the eMMC DDR transmit sequencer.
// The master modport is the block requester; the slave modport is the sequencer.
interface emmc_ddr_tx_sched_if #(
    parameter int MAX_LEN_W = 12
);
    logic                 start;
    logic                 abort;
    logic                 bus_width;
    logic [MAX_LEN_W-1:0] blk_len;
    logic [15:0]          din;
    logic                 din_valid;
    logic                 din_ready;
    logic [7:0]           d1_wire;
    logic [7:0]           d2_wire;
    logic                 oe;
    logic                 sd_clk_en;
    logic                 busy;
    logic                 done;

    modport master (
        output start, abort, bus_width, blk_len, din, din_valid,
        input  din_ready, d1_wire, d2_wire, oe, sd_clk_en, busy, done
    );

    modport slave (
        input  start, abort, bus_width, blk_len, din, din_valid,
        output din_ready, d1_wire, d2_wire, oe, sd_clk_en, busy, done
    );
endinterface

// File: rtl/emmc_ddr_tx_sched.sv
// eMMC DDR write-block framer: start bit, data beats, per-line/per-edge CRC16, end bit.
// Every output is registered one cycle behind the state that produces it.
module emmc_ddr_tx_sched #(
    parameter int MAX_LEN_W = 12
) (
    input logic                clock,
    input logic                reset,
    emmc_ddr_tx_sched_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_END} state_t;

    state_t               state_reg, state_next;
    logic [MAX_LEN_W-1:0] cnt_reg, cnt_next;
    logic [3:0]           idx_reg, idx_next;
    logic                 is8_reg, is8_next;
    logic [7:0]           d1_reg, d1_next;
    logic [7:0]           d2_reg, d2_next;
    logic                 oe_reg, oe_next;
    logic                 en_reg, en_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;

    logic                 beat_take, crc_shift, crc_clr, start_ok;
    logic [MAX_LEN_W-1:0] beats;
    logic [7:0]           beat_d1, beat_d2, lane_pad;
    logic [7:0]           rise_msb, fall_msb;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    assign beats    = bus.bus_width ? (bus.blk_len >> 1) : bus.blk_len;
    // The end-bit cycle is already IDLE but still busy, so a start there is refused.
    assign start_ok = bus.start && !busy_reg && (beats != '0);
    assign beat_d1  = is8_reg ? bus.din[7:0]  : {4'hF, bus.din[7:4]};
    assign beat_d2  = is8_reg ? bus.din[15:8] : {4'hF, bus.din[3:0]};
    assign lane_pad = is8_reg ? 8'h00 : 8'hF0;

    // CRC phase shifts each register left so bit 15 is always the next bit to send.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_line
            logic [15:0] rise_reg, fall_reg;
            always_ff @(posedge clock) begin
                if (reset || crc_clr) begin
                    rise_reg <= '0;
                    fall_reg <= '0;
                end else if (beat_take) begin
                    rise_reg <= crc_step(rise_reg, beat_d1[gi]);
                    fall_reg <= crc_step(fall_reg, beat_d2[gi]);
                end else if (crc_shift) begin
                    rise_reg <= {rise_reg[14:0], 1'b0};
                    fall_reg <= {fall_reg[14:0], 1'b0};
                end
            end
            assign rise_msb[gi] = rise_reg[15];
            assign fall_msb[gi] = fall_reg[15];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            is8_reg   <= 1'b0;
            d1_reg    <= 8'hFF;
            d2_reg    <= 8'hFF;
            oe_reg    <= 1'b0;
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            is8_reg   <= is8_next;
            d1_reg    <= d1_next;
            d2_reg    <= d2_next;
            oe_reg    <= oe_next;
            en_reg    <= en_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        is8_next   = is8_reg;
        d1_next    = d1_reg;
        d2_next    = d2_reg;
        oe_next    = oe_reg;
        en_next    = en_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        beat_take  = 1'b0;
        crc_shift  = 1'b0;
        crc_clr    = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                d1_next   = 8'hFF;
                d2_next   = 8'hFF;
                oe_next   = 1'b0;
                en_next   = 1'b0;
                busy_next = 1'b0;
                done_next = busy_reg;
                if (start_ok) begin
                    state_next = S_DATA;
                    is8_next   = bus.bus_width;
                    cnt_next   = beats;
                    crc_clr    = 1'b1;
                    d1_next    = bus.bus_width ? 8'h00 : 8'hF0;
                    d2_next    = bus.bus_width ? 8'h00 : 8'hF0;
                    oe_next    = 1'b1;
                    en_next    = 1'b1;
                    busy_next  = 1'b1;
                end
            end
            S_DATA: begin
                // A bubble gates the card clock and keeps the wires, so the card never sees it.
                en_next = bus.din_valid;
                if (bus.din_valid) begin
                    beat_take = 1'b1;
                    d1_next   = beat_d1;
                    d2_next   = beat_d2;
                    cnt_next  = cnt_reg - MAX_LEN_W'(1);
                    if (cnt_reg == MAX_LEN_W'(1)) begin
                        state_next = S_CRC;
                        idx_next   = '0;
                    end
                end
            end
            S_CRC: begin
                en_next   = 1'b1;
                crc_shift = 1'b1;
                d1_next   = rise_msb | lane_pad;
                d2_next   = fall_msb | lane_pad;
                idx_next  = idx_reg + 4'd1;
                if (idx_reg == 4'd15) state_next = S_END;
            end
            S_END: begin
                d1_next    = 8'hFF;
                d2_next    = 8'hFF;
                en_next    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (bus.abort && state_reg != S_IDLE) begin
            state_next = S_IDLE;
            d1_next    = 8'hFF;
            d2_next    = 8'hFF;
            oe_next    = 1'b0;
            en_next    = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b0;
            beat_take  = 1'b0;
            crc_shift  = 1'b0;
            crc_clr    = 1'b1;
        end
    end

    assign bus.din_ready = (state_reg == S_DATA);
    assign bus.d1_wire   = d1_reg;
    assign bus.d2_wire   = d2_reg;
    assign bus.oe        = oe_reg;
    assign bus.sd_clk_en = en_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_emmc_ddr_tx_sched.sv
// Randomized bench for emmc_ddr_tx_sched: a cycle-timeline model of each block is built
// from the framing rules, then every output is compared cycle by cycle.
module tb_emmc_ddr_tx_sched;
    localparam int W = 12;
    localparam int N = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    emmc_ddr_tx_sched_if #(.MAX_LEN_W(W)) bus_if ();
    emmc_ddr_tx_sched #(.MAX_LEN_W(W)) dut (.clock(clk), .reset(rst), .bus(bus_if));

    int total = 0;
    int bad   = 0;

    logic [15:0] words [N];
    bit          vmask [N];
    logic [7:0]  e_d1 [N];
    logic [7:0]  e_d2 [N];
    bit          e_oe [N], e_en [N], e_busy [N], e_done [N], e_rdy [N];
    logic [7:0]  obs_d1 [N];
    logic [7:0]  obs_d2 [N];
    logic [7:0]  sav_d1 [N];
    logic [7:0]  sav_d2 [N];
    int          last_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic [15:0] n;
        n = c << 1;
        if (c[15] ^ b) n = n ^ 16'h1021;
        return n;
    endfunction

    // Returns {falling, rising} line vectors for one data word.
    function automatic logic [15:0] lanes(input logic [15:0] w, input bit bw);
        if (bw) return w;
        return {4'hF, w[3:0], 4'hF, w[7:4]};
    endfunction

    task automatic set_idle(input int c);
        e_d1[c] = 8'hFF; e_d2[c] = 8'hFF;
        e_oe[c] = 0; e_en[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_rdy[c] = 0;
    endtask

    task automatic fill_rand(input int stall_pct);
        for (int i = 0; i < N; i++) begin
            words[i] = 16'($urandom);
            vmask[i] = (i >= 600) || (int'($urandom_range(99)) >= stall_pct);
        end
    endtask

    // mode: 0 none, 1 abort anywhere busy, 2 abort during CRC, 3 reset mid-DATA
    task automatic run_block(input bit bw, input logic [W-1:0] len, input int mode,
                             input bit spur, input bit chained, input int extra,
                             input string name);
        int nbt, nb, cl, cut, s, hz, cc;
        logic [15:0] rc [8];
        logic [15:0] fc [8];
        logic [15:0] lw;
        logic [7:0]  act;
        logic [20:0] ob, ex;
        nbt = bw ? int'(len >> 1) : int'(len);
        for (int c = 0; c < N; c++) set_idle(c);
        cut = -1; s = -1; cl = 0; last_done = -1;
        if (nbt == 0) begin
            hz = 1 + extra;
        end else begin
            e_d1[1] = bw ? 8'h00 : 8'hF0; e_d2[1] = e_d1[1];
            e_oe[1] = 1; e_en[1] = 1; e_busy[1] = 1;
            nb = 0; cc = 1;
            while (nb < nbt) begin
                e_rdy[cc] = 1; e_oe[cc+1] = 1; e_busy[cc+1] = 1;
                if (vmask[cc]) begin
                    lw = lanes(words[nb], bw);
                    e_d1[cc+1] = lw[7:0]; e_d2[cc+1] = lw[15:8]; e_en[cc+1] = 1;
                    nb++;
                end else begin
                    e_d1[cc+1] = e_d1[cc]; e_d2[cc+1] = e_d2[cc]; e_en[cc+1] = 0;
                end
                if (nb == nbt) cl = cc;
                cc++;
            end
            for (int n = 0; n < 8; n++) begin rc[n] = '0; fc[n] = '0; end
            for (int b = 0; b < nbt; b++) begin
                lw = lanes(words[b], bw);
                for (int n = 0; n < 8; n++) begin
                    rc[n] = crc_upd(rc[n], lw[n]);
                    fc[n] = crc_upd(fc[n], lw[8+n]);
                end
            end
            act = bw ? 8'hFF : 8'h0F;
            for (int k = 0; k < 16; k++) begin
                cc = cl + 2 + k;
                for (int n = 0; n < 8; n++) begin
                    e_d1[cc][n] = act[n] ? rc[n][15-k] : 1'b1;
                    e_d2[cc][n] = act[n] ? fc[n][15-k] : 1'b1;
                end
                e_oe[cc] = 1; e_en[cc] = 1; e_busy[cc] = 1;
            end
            cc = cl + 18;
            e_d1[cc] = 8'hFF; e_d2[cc] = 8'hFF; e_oe[cc] = 1; e_en[cc] = 1; e_busy[cc] = 1;
            e_done[cl+19] = 1;
            hz = cl + 19 + extra;
            case (mode)
                1: cut = int'($urandom_range(cl + 17, 1));
                2: cut = int'($urandom_range(cl + 16, cl + 1));
                3: cut = int'($urandom_range(cl, 1));
                default: cut = -1;
            endcase
            if (cut >= 0) begin
                for (int c = cut + 1; c < N; c++) set_idle(c);
                hz = cut + 1 + extra;
            end
            if (spur) s = int'($urandom_range((cut >= 0) ? cut : cl + 18, 1));
        end
        $display("blk %s bw=%0d len=%0d beats=%0d mode=%0d cut=%0d spur=%0d", name, bw, len, nbt, mode, cut, s);
        nb = 0;
        for (int c = 0; c <= hz; c++) begin
            if (c > 0 || !chained) begin
                @(negedge clk);
                ob = {bus_if.d1_wire, bus_if.d2_wire, bus_if.oe, bus_if.sd_clk_en,
                      bus_if.busy, bus_if.done, bus_if.din_ready};
                ex = {e_d1[c], e_d2[c], e_oe[c], e_en[c], e_busy[c], e_done[c], e_rdy[c]};
                chk($sformatf("%s c%0d", name, c), {11'd0, ob}, {11'd0, ex});
                obs_d1[c] = bus_if.d1_wire;
                obs_d2[c] = bus_if.d2_wire;
                if (bus_if.done === 1'b1 && last_done < 0) last_done = c;
            end
            bus_if.start     = (c == 0) || (c == s);
            bus_if.bus_width = (c == 0) ? bw : 1'($urandom);
            bus_if.blk_len   = (c == 0) ? len : W'($urandom);
            bus_if.abort     = (mode != 3) && (cut >= 0) && (c == cut);
            rst              = (mode == 3) && (cut >= 0) && (c == cut);
            if (c >= 1 && nb < nbt) begin
                bus_if.din_valid = vmask[c];
                bus_if.din       = vmask[c] ? words[nb] : 16'($urandom);
                if (vmask[c]) nb++;
            end else begin
                bus_if.din_valid = 1'($urandom);
                bus_if.din       = 16'($urandom);
            end
        end
    endtask

    initial begin
        int   d0;
        bit   bw, chain, nxt_chain;
        int   md, nbt, ln;
        logic [15:0] pat;
        bus_if.start = 0; bus_if.abort = 0; bus_if.bus_width = 0; bus_if.blk_len = '0;
        bus_if.din = '0; bus_if.din_valid = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", {11'd0, bus_if.d1_wire, bus_if.d2_wire, bus_if.oe, bus_if.sd_clk_en,
                      bus_if.busy, bus_if.done, bus_if.din_ready},
            {11'd0, 8'hFF, 8'hFF, 5'b00000});
        rst = 0;

        // 8-bit, two words, no stalls
        fill_rand(0);
        words[0] = 16'h2211; words[1] = 16'h4433;
        run_block(1'b1, 12'd4, 0, 1'b0, 1'b0, 2, "b8_len4");
        chk("b8_len4 d1 beat0", {24'd0, obs_d1[2]}, 32'h11);
        chk("b8_len4 d2 beat0", {24'd0, obs_d2[2]}, 32'h22);
        chk("b8_len4 d1 beat1", {24'd0, obs_d1[3]}, 32'h33);
        chk("b8_len4 d2 beat1", {24'd0, obs_d2[3]}, 32'h44);

        // 512 zero bytes: CRC cycles all zero, end bit at T+274
        fill_rand(0);
        for (int i = 0; i < 256; i++) words[i] = 16'h0000;
        run_block(1'b1, 12'd512, 0, 1'b0, 1'b0, 2, "b8_len512");
        for (int k = 0; k < 16; k++)
            chk($sformatf("zero crc k%0d", k), {16'd0, obs_d1[258+k], obs_d2[258+k]}, 32'h0);
        chk("len512 end bit", {16'd0, obs_d1[274], obs_d2[274]}, 32'hFFFF);

        // 4-bit single byte 0x80: line 3 rising CRC is 0x1021
        fill_rand(0);
        words[0] = 16'h0080;
        run_block(1'b0, 12'd1, 0, 1'b0, 1'b0, 2, "b4_len1");
        chk("b4 data d1", {24'd0, obs_d1[2]}, 32'hF8);
        chk("b4 data d2", {24'd0, obs_d2[2]}, 32'hF0);
        pat = 16'h1021;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("b4 crc d1 k%0d", k), {24'd0, obs_d1[3+k]}, 32'hF0 | (32'(pat[15-k]) << 3));
            chk($sformatf("b4 crc d2 k%0d", k), {24'd0, obs_d2[3+k]}, 32'hF0);
        end

        // Stall: same data with and without a 3-cycle bubble
        fill_rand(0);
        run_block(1'b1, 12'd16, 0, 1'b0, 1'b0, 2, "nostall");
        d0 = last_done;
        for (int i = 0; i < N; i++) begin sav_d1[i] = obs_d1[i]; sav_d2[i] = obs_d2[i]; end
        vmask[4] = 0; vmask[5] = 0; vmask[6] = 0;
        run_block(1'b1, 12'd16, 0, 1'b0, 1'b0, 2, "stall3");
        chk("stall done delay", 32'(last_done), 32'(d0 + 3));
        for (int k = 0; k < 16; k++)
            chk($sformatf("stall crc k%0d", k), {16'd0, obs_d1[d0-17+3+k], obs_d2[d0-17+3+k]},
                {16'd0, sav_d1[d0-17+k], sav_d2[d0-17+k]});

        // Abort in CRC, zero-length and sub-beat starts, start while busy, reset mid-DATA
        fill_rand(20);
        run_block(1'b1, 12'd10, 2, 1'b1, 1'b0, 2, "abort_crc");
        run_block(1'b1, 12'd0, 0, 1'b0, 1'b0, 3, "len0");
        run_block(1'b1, 12'd1, 0, 1'b0, 1'b0, 3, "b8_len1");
        run_block(1'b0, 12'd0, 0, 1'b0, 1'b0, 3, "b4_len0");
        fill_rand(20);
        run_block(1'b1, 12'd20, 3, 1'b0, 1'b0, 2, "reset_mid");
        fill_rand(20);
        run_block(1'b1, 12'd20, 0, 1'b1, 1'b0, 2, "after_reset");

        // Random blocks, some chained back-to-back on the done cycle
        chain = 0;
        for (int t = 0; t < 24; t++) begin
            fill_rand(25);
            bw  = 1'($urandom);
            ln  = int'($urandom_range(40, 0));
            nbt = bw ? (ln >> 1) : ln;
            md  = int'($urandom_range(5, 0));
            if (md > 3) md = 0;
            nxt_chain = (md == 0) && (nbt > 0) && ($urandom_range(2) == 0) && (t < 23);
            run_block(bw, W'(ln), md, 1'($urandom), chain, nxt_chain ? 0 : 2,
                      $sformatf("rnd%0d", t));
            chain = nxt_chain;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
